// File: rtl/spi_pkg.sv
// Shared definitions for the SPI endpoints (slave here, master elsewhere).
//   spi_state_e     : frame-level controller states
//   SPI_BYTE_W      : frame width in bits
//   sample_on_rise  : 1 when the data sample edge is SCLK rising for the
//                     given (cpol, cpha) mode pair
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } spi_state_e;

    // Modes 0 and 3 sample on rising SCLK, modes 1 and 2 on falling SCLK.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return (cpol ^ cpha) == 1'b0;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Single-bit flop-chain synchronizer for asynchronous pin inputs.
//   clk_i   : system clock
//   rstn_i  : async active-low reset; every stage resets to p_rst_val
//   d_i     : asynchronous input
//   q_o     : synchronized output, p_stages clk_i cycles behind d_i
module spi_sync #(
    parameter int   p_stages  = 2,
    parameter logic p_rst_val = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [p_stages-1:0] ff_q;

    if (p_stages < 2) begin : g_bad_depth
        $error("spi_sync: p_stages must be at least 2");
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ff_q <= {p_stages{p_rst_val}};
        end else begin
            ff_q <= {ff_q[p_stages-2:0], d_i};
        end
    end

    assign q_o = ff_q[p_stages-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint, fully oversampled in the clk_i domain.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | not selected; MISO tri-stated (oe=0), edges ignored
// S_ACTIVE | selected; sample edges shift RX in, shift edges drive TX out
//
// Ports:
//   clk_i, rstn_i       : system clock, async active-low reset
//   sclk_i, cs_i, mosi_i: raw SPI pins from the master (asynchronous)
//   miso_o, miso_oe_o   : slave-out data and its output enable
//   tx_data_i/tx_load_i : write into the single-entry TX buffer when tx_ready_o
//   tx_ready_o          : TX buffer empty
//   rx_data_o/rx_valid_o: last complete byte, one-cycle valid pulse
//   tx_underrun_o       : one-cycle pulse, a byte started with an empty buffer
//   busy_o              : selected (synchronized cs low)
module spi_slave
    import spi_pkg::*;
#(
    parameter logic p_cpol        = 1'b0,
    parameter logic p_cpha        = 1'b0,
    parameter int   p_sync_stages = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  sclk_i,
    input  logic                  cs_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [SPI_BYTE_W-1:0] tx_data_i,
    input  logic                  tx_load_i,
    output logic                  tx_ready_o,
    output logic [SPI_BYTE_W-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  tx_underrun_o,
    output logic                  busy_o
);

    localparam logic                SAMPLE_RISE = sample_on_rise(p_cpol, p_cpha);
    localparam int                  CNT_W       = $clog2(SPI_BYTE_W);
    localparam logic [CNT_W-1:0]    LAST_BIT    = CNT_W'(SPI_BYTE_W - 1);

    // ---------------- pin synchronization and edge detection ----------------
    logic sclk_s, cs_s, mosi_s;
    logic sclk_q, cs_q;

    spi_sync #(.p_stages(p_sync_stages), .p_rst_val(p_cpol)) u_sync_sclk (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (sclk_i),
        .q_o    (sclk_s)
    );

    spi_sync #(.p_stages(p_sync_stages), .p_rst_val(1'b1)) u_sync_cs (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (cs_i),
        .q_o    (cs_s)
    );

    spi_sync #(.p_stages(p_sync_stages), .p_rst_val(1'b0)) u_sync_mosi (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (mosi_i),
        .q_o    (mosi_s)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sclk_q <= p_cpol;
            cs_q   <= 1'b1;
        end else begin
            sclk_q <= sclk_s;
            cs_q   <= cs_s;
        end
    end

    logic sclk_rise, sclk_fall, sample_edge, shift_edge, cs_fall, cs_rise;

    assign sclk_rise   = sclk_s & ~sclk_q;
    assign sclk_fall   = ~sclk_s & sclk_q;
    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
    assign cs_fall     = ~cs_s & cs_q;
    assign cs_rise     = cs_s & ~cs_q;

    // ---------------- frame controller ----------------
    spi_state_e state_q, state_d;

    logic                  sample_act, shift_act, load_now, frame_abort;
    logic                  pend_set, pend_clr;
    logic                  load_pend_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [SPI_BYTE_W-1:0] rx_shift_q, tx_shift_q, tx_buf_q;
    logic                  tx_full_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // load_pend marks "the next shift edge starts a new byte": set at select
    // for cpha=1 (first edge of the frame is a shift edge) and after every
    // 8th sample edge in both modes. For cpha=0 the first byte of a frame is
    // loaded directly at select so its MSB is on MISO before the first edge.
    always_comb begin
        state_d     = state_q;
        sample_act  = 1'b0;
        shift_act   = 1'b0;
        load_now    = 1'b0;
        frame_abort = 1'b0;
        pend_set    = 1'b0;
        pend_clr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d  = S_ACTIVE;
                    load_now = ~p_cpha;
                    pend_set = p_cpha;
                end
            end
            S_ACTIVE: begin
                if (cs_rise) begin
                    state_d     = S_IDLE;
                    frame_abort = 1'b1;
                    pend_clr    = 1'b1;
                end else begin
                    sample_act = sample_edge;
                    shift_act  = shift_edge;
                    load_now   = shift_edge & load_pend_q;
                    pend_clr   = shift_edge & load_pend_q;
                    pend_set   = sample_edge & (bit_cnt_q == LAST_BIT);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            load_pend_q <= 1'b0;
        end else if (pend_clr) begin
            load_pend_q <= 1'b0;
        end else if (pend_set) begin
            load_pend_q <= 1'b1;
        end
    end

    // ---------------- receive path ----------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            if (frame_abort) begin
                // partial byte is dropped without a valid pulse
                rx_shift_q <= '0;
                bit_cnt_q  <= '0;
            end else if (sample_act) begin
                rx_shift_q <= {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
                if (bit_cnt_q == LAST_BIT) begin
                    rx_data_o  <= {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
                    rx_valid_o <= 1'b1;
                    bit_cnt_q  <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end
        end
    end

    // ---------------- transmit path ----------------
    // A load with the buffer full consumes it; loading while empty sends
    // zeros and flags an underrun. tx_load_i is only honoured while empty,
    // so a write can never collide with a consume.
    logic tx_accept;
    assign tx_accept = tx_load_i & ~tx_full_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_full_q     <= 1'b0;
            tx_buf_q      <= '0;
            tx_shift_q    <= '0;
            tx_underrun_o <= 1'b0;
        end else begin
            tx_underrun_o <= load_now & ~tx_full_q;
            if (load_now && tx_full_q) begin
                tx_full_q <= 1'b0;
            end else if (tx_accept) begin
                tx_full_q <= 1'b1;
                tx_buf_q  <= tx_data_i;
            end
            if (frame_abort) begin
                tx_shift_q <= '0;
            end else if (load_now) begin
                tx_shift_q <= tx_full_q ? tx_buf_q : '0;
            end else if (shift_act) begin
                tx_shift_q <= {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
            end
        end
    end

    // ---------------- outputs ----------------
    assign busy_o     = (state_q == S_ACTIVE);
    assign miso_oe_o  = (state_q == S_ACTIVE);
    assign miso_o     = miso_oe_o ? tx_shift_q[SPI_BYTE_W-1] : 1'b0;
    assign tx_ready_o = ~tx_full_q;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    localparam int HALF = 8;   // SCLK half period in clk cycles (>= 6)

    logic       clk;
    logic       rstn;
    logic       sclk     [4];
    logic       cs       [4];
    logic       mosi     [4];
    logic       miso     [4];
    logic       miso_oe  [4];
    logic [7:0] tx_data  [4];
    logic       tx_load  [4];
    logic       tx_ready [4];
    logic [7:0] rx_data  [4];
    logic       rx_valid [4];
    logic       underrun [4];
    logic       busy     [4];

    int tests_run = 0;
    int failures  = 0;

    // reference model state: byte left in the TX buffer after a frame
    bit         has_ret [4];
    logic [7:0] ret_val [4];

    // monitors
    int         rx_cnt  [4];
    int         und_cnt [4];
    logic [7:0] rx_log  [4][64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(
            .p_cpol        (g >= 2 ? 1'b1 : 1'b0),
            .p_cpha        ((g % 2) == 1 ? 1'b1 : 1'b0),
            .p_sync_stages (2)
        ) u_dut (
            .clk_i         (clk),
            .rstn_i        (rstn),
            .sclk_i        (sclk[g]),
            .cs_i          (cs[g]),
            .mosi_i        (mosi[g]),
            .miso_o        (miso[g]),
            .miso_oe_o     (miso_oe[g]),
            .tx_data_i     (tx_data[g]),
            .tx_load_i     (tx_load[g]),
            .tx_ready_o    (tx_ready[g]),
            .rx_data_o     (rx_data[g]),
            .rx_valid_o    (rx_valid[g]),
            .tx_underrun_o (underrun[g]),
            .busy_o        (busy[g])
        );
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_valid[i] === 1'b1) begin
                rx_log[i][rx_cnt[i] % 64] = rx_data[i];
                rx_cnt[i]++;
            end
            if (underrun[i] === 1'b1) und_cnt[i]++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One cs window on mode m: nbits bits from mo (MSB first); the bench
    // loads up to two bytes whenever tx_ready is high. Expected results are
    // derived from the frame-level rules: the slave starts a new TX byte at
    // select (cpha=0) and after each full byte (cpha=0), or at the start of
    // every byte (cpha=1); each start takes the oldest available byte or 0.
    task automatic frame(input int m, input int nbits, input logic [15:0] mo,
                         input int nload, input logic [7:0] ld0, input logic [7:0] ld1);
        logic [7:0] list[$];
        logic [15:0] mi;
        logic [7:0] exp_b, got_b;
        int loads, nfull, und_exp, rx_base, und_base, idx;
        bit cpol, cpha, mdone;
        cpol = (m >= 2);
        cpha = ((m % 2) == 1);
        if (has_ret[m]) list.push_back(ret_val[m]);
        if (nload > 0) list.push_back(ld0);
        if (nload > 1) list.push_back(ld1);
        nfull   = nbits / 8;
        loads   = cpha ? (nbits + 7) / 8 : 1 + nfull;
        und_exp = (loads > list.size()) ? loads - list.size() : 0;
        rx_base  = rx_cnt[m];
        und_base = und_cnt[m];
        mi = '0; mdone = 0; idx = 0;
        fork
            begin
                sclk[m] = cpol;
                wait_n(4);
                if (!cpha) mosi[m] = mo[15];
                cs[m] = 1'b0;
                wait_n(HALF);
                tests_run++;
                if (busy[m] !== 1'b1 || miso_oe[m] !== 1'b1) begin
                    failures++;
                    $display("FAIL select_m%0d: busy=%b oe=%b required 1 1", m, busy[m], miso_oe[m]);
                end
                if (!cpha && list.size() <= 1) begin
                    tests_run++;
                    if (tx_ready[m] !== 1'b1) begin
                        failures++;
                        $display("FAIL ready_after_cs_m%0d: got %b required 1", m, tx_ready[m]);
                    end
                end
                for (int i = 0; i < nbits; i++) begin
                    if (!cpha) begin
                        mi[15-i] = miso[m];
                        sclk[m] = ~cpol;
                        wait_n(HALF);
                        sclk[m] = cpol;
                        if (i + 1 < nbits) mosi[m] = mo[14-i];
                        wait_n(HALF);
                    end else begin
                        sclk[m] = ~cpol;
                        mosi[m] = mo[15-i];
                        wait_n(HALF);
                        mi[15-i] = miso[m];
                        sclk[m] = cpol;
                        wait_n(HALF);
                    end
                end
                cs[m] = 1'b1;
                mosi[m] = 1'b0;
                wait_n(2 * HALF);
                mdone = 1;
            end
            begin
                while (!mdone) begin
                    @(negedge clk);
                    if (tx_ready[m] === 1'b1 && idx < nload && !mdone) begin
                        tx_data[m] = (idx == 0) ? ld0 : ld1;
                        tx_load[m] = 1'b1;
                        idx++;
                    end else begin
                        tx_load[m] = 1'b0;
                    end
                end
                tx_load[m] = 1'b0;
            end
        join

        tests_run++;
        if (rx_cnt[m] - rx_base != nfull) begin
            failures++;
            $display("FAIL rx_count_m%0d: got %0d required %0d", m, rx_cnt[m] - rx_base, nfull);
        end
        for (int b = 0; b < nfull; b++) begin
            exp_b = mo[15-8*b -: 8];
            got_b = rx_log[m][(rx_base + b) % 64];
            tests_run++;
            if (got_b !== exp_b) begin
                failures++;
                $display("FAIL rx_byte%0d_m%0d: got %h required %h", b, m, got_b, exp_b);
            end
            exp_b = (b < list.size()) ? list[b] : 8'h00;
            got_b = mi[15-8*b -: 8];
            tests_run++;
            if (got_b !== exp_b) begin
                failures++;
                $display("FAIL miso_byte%0d_m%0d: got %h required %h", b, m, got_b, exp_b);
            end
        end
        tests_run++;
        if (und_cnt[m] - und_base != und_exp) begin
            failures++;
            $display("FAIL underrun_m%0d: got %0d pulses required %0d", m, und_cnt[m] - und_base, und_exp);
        end
        if (list.size() > loads) begin
            has_ret[m] = 1;
            ret_val[m] = list[loads];
        end else begin
            has_ret[m] = 0;
        end
        tests_run++;
        if (tx_ready[m] !== !has_ret[m]) begin
            failures++;
            $display("FAIL tx_ready_end_m%0d: got %b required %b", m, tx_ready[m], !has_ret[m]);
        end
        tests_run++;
        if (busy[m] !== 1'b0 || miso_oe[m] !== 1'b0 || miso[m] !== 1'b0) begin
            failures++;
            $display("FAIL deselect_m%0d: busy=%b oe=%b miso=%b required 0 0 0", m, busy[m], miso_oe[m], miso[m]);
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int m = 0; m < 4; m++) begin
            tests_run++;
            if (miso[m] !== 1'b0 || miso_oe[m] !== 1'b0 || tx_ready[m] !== 1'b1 ||
                rx_data[m] !== 8'h00 || rx_valid[m] !== 1'b0 || underrun[m] !== 1'b0 ||
                busy[m] !== 1'b0) begin
                failures++;
                $display("FAIL %s_m%0d: miso=%b oe=%b rdy=%b rx=%h vld=%b und=%b busy=%b required 0 0 1 00 0 0 0",
                         tag, m, miso[m], miso_oe[m], tx_ready[m], rx_data[m], rx_valid[m],
                         underrun[m], busy[m]);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int m = 0; m < 4; m++) begin
            sclk[m] = (m >= 2); cs[m] = 1'b1; mosi[m] = 1'b0;
            tx_data[m] = 8'h00; tx_load[m] = 1'b0;
            has_ret[m] = 0; ret_val[m] = 8'h00; rx_cnt[m] = 0; und_cnt[m] = 0;
        end
        wait_n(3);
        check_reset_values("reset");
        rstn = 1'b1;
        wait_n(5);
        check_reset_values("after_reset");
    endtask

    task automatic test_mode0_basic();
        frame(0, 8, {8'h3C, 8'h00}, 1, 8'hA5, 8'h00);
    endtask

    task automatic test_modes_123();
        for (int m = 1; m < 4; m++) frame(m, 8, {8'hC3, 8'h00}, 1, 8'h5A, 8'h00);
    endtask

    task automatic test_back_to_back();
        frame(0, 16, {8'h9E, 8'h47}, 2, 8'h11, 8'h22);
        frame(3, 16, {8'h0F, 8'hE1}, 2, 8'h11, 8'h22);
    endtask

    task automatic test_underrun();
        frame(1, 8, {8'h6B, 8'h00}, 0, 8'h00, 8'h00);
    endtask

    task automatic test_abort();
        frame(0, 5, {8'hAB, 8'h00}, 2, 8'h77, 8'h88);
        frame(0, 8, {8'hF0, 8'h00}, 0, 8'h00, 8'h00);
    endtask

    task automatic test_reset_mid();
        sclk[0] = 1'b0;
        mosi[0] = 1'b1;
        tx_data[0] = 8'hC7; tx_load[0] = 1'b1;
        wait_n(1);
        tx_load[0] = 1'b0;
        cs[0] = 1'b0;
        wait_n(HALF);
        for (int i = 0; i < 3; i++) begin
            sclk[0] = 1'b1; wait_n(HALF);
            sclk[0] = 1'b0; wait_n(HALF);
        end
        sclk[0] = 1'b1;
        wait_n(4);
        #1 rstn = 1'b0;
        #1;
        check_reset_values("reset_mid");
        cs[0] = 1'b1; sclk[0] = 1'b0; mosi[0] = 1'b0;
        for (int m = 0; m < 4; m++) has_ret[m] = 0;
        wait_n(4);
        rstn = 1'b1;
        wait_n(4);
        frame(0, 8, {8'hF0, 8'h00}, 1, 8'h96, 8'h00);
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            int m, nb, nl;
            logic [15:0] mo;
            logic [7:0] a, b;
            m  = $urandom_range(0, 3);
            nb = ($urandom_range(0, 1) == 1) ? 16 : 8;
            nl = $urandom_range(0, 2);
            mo = 16'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            frame(m, nb, mo, nl, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_basic();
        test_modes_123();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI peripheral (slave) endpoint: receives 8-bit frames from an external SPI master on MOSI and returns 8-bit frames on MISO. All SPI pins are oversampled in the system clock domain through synchronizers; no logic is clocked by SCLK. It sits between the off-chip/pin SPI bus and an internal byte-stream consumer/producer, and is mode-compatible with the team's SPI master for loopback testing.

## Interface
- p_cpol, 1'b0, idle level of SCLK
- p_cpha, 1'b0, 0: sample on first edge, 1: sample on second edge
- p_sync_stages, 2, synchronizer depth for sclk_i/cs_i/mosi_i (≥2)

- clk_i  in  1  system clock; one clock; everything rises on it
- rstn_i  in  1  reset, asynchronous assert, active-low
- sclk_i  in  1  SPI clock from master (asynchronous)
- cs_i  in  1  chip select, active-low (asynchronous)
- mosi_i  in  1  master-out data (asynchronous)
- miso_o  out  1  slave-out data
- miso_oe_o  out  1  MISO output enable (1 while selected)
- tx_data_i  in  8  next byte to transmit
- tx_load_i  in  1  write tx_data_i into TX buffer when tx_ready_o=1
- tx_ready_o  out  1  TX buffer empty
- rx_data_o  out  8  last complete received byte
- rx_valid_o  out  1  one-cycle pulse, rx_data_o updated
- tx_underrun_o  out  1  one-cycle pulse, byte started with empty TX buffer
- busy_o  out  1  selected (synchronized cs low)

## Operation
- Sample edge: rising if p_cpol^p_cpha==0, else falling. Shift edge: the opposite one. Edges detected from the last two synchronized SCLK samples.
- States: S_IDLE, S_ACTIVE. S_IDLE→S_ACTIVE on synchronized cs falling; S_ACTIVE→S_IDLE on synchronized cs rising (from any bit position).
- Byte start (cs assert, or after 8th sample edge): shift register loads TX buffer, buffer becomes empty (tx_ready_o=1). If buffer empty: load 8'h00, pulse tx_underrun_o.
- p_cpha=0: load at cs assert (MSB on miso_o immediately); subsequent bytes load on the first shift edge after the 8th sample edge; other shift edges shift left.
- p_cpha=1: load on the first shift edge of each byte (no shift); later shift edges shift left.
- Sample edge: rx shift register shifts in synchronized mosi (MSB first), bit counter 0..7 increments. At count 7→wrap: rx_data_o ← assembled byte, rx_valid_o pulses, counter ← 0.
- cs deassert mid-byte: partial RX byte discarded (no rx_valid_o), counter ← 0, shift register cleared; an unconsumed TX buffer byte is retained.
- TX buffer: single entry. tx_load_i with tx_ready_o=0 is ignored. tx_load_i on the same cycle as buffer consumption is ignored (tx_ready_o still 0 that cycle).
- miso_o = shift register MSB when miso_oe_o=1, else 0.

## Timing
- Reset values: miso_o 0, miso_oe_o 0, tx_ready_o 1, rx_data_o 8'h00, rx_valid_o 0, tx_underrun_o 0, busy_o 0; synchronizers reset to sclk=p_cpol, cs=1, mosi=0; state S_IDLE, counter 0.
- Pin-to-detect latency: p_sync_stages+1 clk_i cycles.
- rx_valid_o: p_sync_stages+1 cycles after the 8th sample edge at the pin.
- miso_o update: p_sync_stages+1 cycles after shift edge / cs assert.
- Constraint: each SCLK half-period ≥ 2·(p_sync_stages+1) clk_i cycles (f_sclk ≤ f_clk/12 at default); cs-assert to first SCLK edge and last edge to cs-deassert same minimum.
- busy_o and miso_oe_o follow synchronized cs, registered.

## Structure
- Shared package spi_pkg: state encodings S_IDLE/S_ACTIVE, sample-edge-select function of (cpol,cpha), byte width constant 8 (shared with the master).
- Sub-module spi_sync: parameterized-depth flop synchronizer with async active-low reset and reset-value parameter; three instances.

## Test plan
- Mode 0, TX buffer preloaded 8'hA5, master sends 8'h3C → rx_data_o=8'h3C with one rx_valid_o pulse; master receives 8'hA5; tx_ready_o=1 after cs assert.
- Modes 1, 2, 3 each: master sends 8'hC3, slave returns 8'h5A → both bytes correct; repeat with the team SPI master in loopback at f_clk/12.
- Two back-to-back bytes in one cs window (TX 8'h11 then 8'h22 loaded after tx_ready_o) → master reads 11,22; two rx_valid_o pulses.
- No TX load before cs → tx_underrun_o pulses once, master receives 8'h00.
- cs released after 5 bits → no rx_valid_o, counter 0; next full frame 8'hF0 received correctly.
- rstn_i asserted mid-byte → all outputs at reset values immediately; next frame after release correct.
